// File: rtl/decode_pipe_stage.sv
// Decode stage: combinational instruction decode feeding a DEPTH-entry circular buffer.
// Optional macro DECODE_ILLEGAL_TRAP_EN enables illegal-instruction flagging.
module decode_pipe_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [16:0]     out_ctrl,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic [3:0]  alu_op;
    logic [2:0]  dataout_src;
    logic [1:0]  alu_srca;
    logic [1:0]  mem_wdsrc;
    logic        alu_srcb;
    logic        mem_we;
    logic        reg_we;
    logic        branch;
    logic        jalr;
    logic        jump;
    logic        illegal;
    logic signed [31:0] imm32;
    logic [16:0]     ctrl_next;
    logic [XLEN-1:0] imm_next;

    always_comb begin
        alu_op      = 4'b0000;
        dataout_src = 3'b000;
        alu_srca    = 2'b00;
        mem_wdsrc   = 2'b00;
        alu_srcb    = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        branch      = 1'b0;
        jalr        = 1'b0;
        jump        = 1'b0;
        illegal     = 1'b0;
        imm32       = '0;
        case (opcode)
            OPC_LUI: begin
                reg_we      = 1'b1;
                dataout_src = 3'b011;
                alu_srca    = 2'b10;
                alu_srcb    = 1'b1;
                imm32       = imm_u;
            end
            OPC_AUIPC: begin
                reg_we   = 1'b1;
                alu_srca = 2'b01;
                alu_srcb = 1'b1;
                imm32    = imm_u;
            end
            OPC_JAL: begin
                reg_we      = 1'b1;
                jump        = 1'b1;
                dataout_src = 3'b010;
                alu_srca    = 2'b01;
                alu_srcb    = 1'b1;
                imm32       = imm_j;
            end
            OPC_JALR: begin
                reg_we      = 1'b1;
                jalr        = 1'b1;
                dataout_src = 3'b010;
                alu_srcb    = 1'b1;
                imm32       = imm_i;
            end
            OPC_BRANCH: begin
                branch = 1'b1;
                alu_op = {1'b1, funct3};
                imm32  = imm_b;
            end
            OPC_LOAD: begin
                reg_we      = 1'b1;
                dataout_src = 3'b001;
                alu_srcb    = 1'b1;
                mem_wdsrc   = funct3[1:0];
                imm32       = imm_i;
            end
            OPC_STORE: begin
                mem_we    = 1'b1;
                alu_srcb  = 1'b1;
                mem_wdsrc = funct3[1:0];
                imm32     = imm_s;
            end
            OPC_OPIMM: begin
                reg_we   = 1'b1;
                alu_srcb = 1'b1;
                // Only the shift-right encoding distinguishes SRLI/SRAI via bit 30
                alu_op   = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                imm32    = imm_i;
            end
            OPC_OP: begin
                reg_we = 1'b1;
                alu_op = {funct7[5], funct3};
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
`endif
            end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
        endcase
        if (illegal) begin
            reg_we = 1'b0;
            mem_we = 1'b0;
            branch = 1'b0;
            jalr   = 1'b0;
            jump   = 1'b0;
        end
    end

    assign ctrl_next = {alu_op, dataout_src, alu_srca, mem_wdsrc,
                        alu_srcb, mem_we, reg_we, branch, jalr, jump};
    assign imm_next  = XLEN'(imm32);

    // ------------------------------------------------------------------
    // Circular buffer control
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;

    // Reset gates in_ready directly so it reads 0 throughout the reset window
    assign in_ready  = rst_n && (count_reg != FULL_COUNT);
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: no reset needed, contents are qualified by count
    // ------------------------------------------------------------------
    logic [16:0]     ctrl_mem [DEPTH];
    logic [XLEN-1:0] imm_mem  [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [4:0]      rd_mem   [DEPTH];
    logic [4:0]      rs1_mem  [DEPTH];
    logic [4:0]      rs2_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            ctrl_mem[wr_ptr_reg] <= ctrl_next;
            imm_mem[wr_ptr_reg]  <= imm_next;
            pc_mem[wr_ptr_reg]   <= in_pc;
            rd_mem[wr_ptr_reg]   <= in_instr[11:7];
            rs1_mem[wr_ptr_reg]  <= in_instr[19:15];
            rs2_mem[wr_ptr_reg]  <= in_instr[24:20];
        end
    end

    assign out_ctrl = out_valid ? ctrl_mem[rd_ptr_reg] : '0;
    assign out_imm  = out_valid ? imm_mem[rd_ptr_reg]  : '0;
    assign out_pc   = pc_mem[rd_ptr_reg];
    assign out_rd   = rd_mem[rd_ptr_reg];
    assign out_rs1  = rs1_mem[rd_ptr_reg];
    assign out_rs2  = rs2_mem[rd_ptr_reg];

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic ill_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            ill_mem[wr_ptr_reg] <= illegal;
        end
    end

    assign out_illegal = out_valid ? ill_mem[rd_ptr_reg] : 1'b0;
`else
    assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: reference decode pushed on accept, compared on pop.
// Follows the DUT's DECODE_ILLEGAL_TRAP_EN setting.
module tb_decode_pipe_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_instr = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [16:0]     out_ctrl;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    decode_pipe_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_imm(out_imm),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [16:0]     ctrl;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd, rs1, rs2;
        logic [XLEN-1:0] pc;
        logic            ill;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decode, written from the opcode table
    function automatic exp_t ref_decode(input logic [31:0] i, input logic [XLEN-1:0] pc);
        exp_t e;
        logic [3:0] aop;
        logic [2:0] ds;
        logic [1:0] sa, wd;
        logic sb, mw, rw, br, jr, jp, ill;
        logic signed [31:0] t;
        logic signed [31:0] imm;
        logic [2:0] f3;
        aop = 0; ds = 0; sa = 0; wd = 0; sb = 0; mw = 0; rw = 0; br = 0; jr = 0; jp = 0; ill = 0;
        imm = 0;
        f3 = i[14:12];
        case (i[6:0])
            7'h37: begin rw = 1; ds = 3'd3; sa = 2'd2; sb = 1; imm = {i[31:12], 12'b0}; end
            7'h17: begin rw = 1; sa = 2'd1; sb = 1; imm = {i[31:12], 12'b0}; end
            7'h6F: begin rw = 1; jp = 1; ds = 3'd2; sa = 2'd1; sb = 1;
                         t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}; imm = t >>> 11; end
            7'h67: begin rw = 1; jr = 1; ds = 3'd2; sb = 1; t = i; imm = t >>> 20; end
            7'h63: begin br = 1; aop = {1'b1, f3};
                         t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}; imm = t >>> 19; end
            7'h03: begin rw = 1; ds = 3'd1; sb = 1; wd = f3[1:0]; t = i; imm = t >>> 20; end
            7'h23: begin mw = 1; sb = 1; wd = f3[1:0];
                         t = {i[31:25], i[11:7], 20'b0}; imm = t >>> 20; end
            7'h13: begin rw = 1; sb = 1; aop = {(f3 == 3'd5) & i[30], f3}; t = i; imm = t >>> 20; end
            7'h33: begin rw = 1; aop = {i[30], f3};
`ifdef DECODE_ILLEGAL_TRAP_EN
                         ill = !(i[31:25] == 7'h00 || i[31:25] == 7'h20);
`endif
                   end
            default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
                ill = 1;
`endif
            end
        endcase
        if (ill) begin rw = 0; mw = 0; br = 0; jr = 0; jp = 0; end
        e.ctrl = {aop, ds, sa, wd, sb, mw, rw, br, jr, jp};
        e.imm  = XLEN'(imm);
        e.rd   = i[11:7];
        e.rs1  = i[19:15];
        e.rs2  = i[24:20];
        e.pc   = pc;
        e.ill  = ill;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [10];
        logic [31:0] r;
        logic [6:0] opc;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
        r   = $urandom;
        opc = ops[$urandom_range(0, 9)];
        if (opc == 7'h33 && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return {r[31:7], opc};
    endfunction

    // One clock: check model state, score any pop, record any push.
    task automatic cycle();
        exp_t e;
        bit   m_ready, m_valid;
        @(negedge clk);
        m_ready = (sb_q.size() != DEPTH);
        m_valid = (sb_q.size() != 0);
        check_eq("in_ready", in_ready, m_ready);
        check_eq("out_valid", out_valid, m_valid);
        if (!m_valid) begin
            check_eq("idle_ctrl", out_ctrl, 0);
            check_eq("idle_imm", out_imm, 0);
            check_eq("idle_ill", out_illegal, 0);
        end else if (out_ready && !flush) begin
            e = sb_q.pop_front();
            check_eq("pop_ctrl", out_ctrl, e.ctrl);
            check_eq("pop_imm", out_imm, e.imm);
            check_eq("pop_regs", {out_rd, out_rs1, out_rs2}, {e.rd, e.rs1, e.rs2});
            check_eq("pop_pc", out_pc, e.pc);
            check_eq("pop_ill", out_illegal, e.ill);
            $display("pop pc=%h ctrl=%05h imm=%h rd=%0d ill=%0b", out_pc, out_ctrl, out_imm, out_rd, out_illegal);
        end
        if (in_valid && m_ready && !flush) sb_q.push_back(ref_decode(in_instr, in_pc));
        if (flush) sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic r, input logic f);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = in_pc + XLEN'(4);
        out_ready = r;
        flush     = f;
    endtask

    logic [XLEN-1:0] neg4;
    logic [XLEN-1:0] pc_mark;

    initial begin
        neg4 = ~XLEN'(3);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_ctrl", out_ctrl, 0);
        check_eq("rst_imm", out_imm, 0);
        check_eq("rst_ill", out_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // addi x1,x0,5 visible one cycle after push
        drive(1, 32'h00500093, 0, 0);
        cycle();
        drive(0, 32'h0, 0, 0);
        check_eq("addi_valid", out_valid, 1);
        check_eq("addi_ctrl", out_ctrl, 17'h00028);
        check_eq("addi_imm", out_imm, 5);
        check_eq("addi_rd", out_rd, 1);
        cycle();
        drive(0, 32'h0, 1, 0);
        cycle();

        // Fill with out_ready low, then drain in order and run through a wrap
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, rand_instr(), 0, 0);
            cycle();
        end
        check_eq("full_in_ready", in_ready, 0);
        drive(1, rand_instr(), 0, 0);
        cycle();
        for (int k = 0; k < 3 * DEPTH + 1; k++) begin
            drive(k < 2 * DEPTH, rand_instr(), 1, 0);
            cycle();
        end

        // count=1 with push and pop together
        drive(1, rand_instr(), 0, 0);
        cycle();
        drive(1, rand_instr(), 1, 0);
        pc_mark = in_pc;
        cycle();
        check_eq("pp_valid", out_valid, 1);
        check_eq("pp_pc", out_pc, pc_mark);
        drive(0, 32'h0, 1, 0);
        cycle();

        // Flush with two buffered and one incoming
        drive(1, rand_instr(), 0, 0); cycle();
        drive(1, rand_instr(), 0, 0); cycle();
        drive(1, 32'h00700113, 1, 1);
        cycle();
        drive(0, 32'h0, 0, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_in_ready", in_ready, 1);
        cycle();

        // Negative branch offset
        drive(1, 32'hFE000EE3, 0, 0);
        cycle();
        drive(0, 32'h0, 0, 0);
        check_eq("beq_ctrl", out_ctrl, 17'h10004);
        check_eq("beq_imm", out_imm, neg4);
        out_ready = 1;
        cycle();

        // Unsupported opcode
        drive(1, 32'h0000007F, 0, 0);
        cycle();
        drive(0, 32'h0, 0, 0);
        check_eq("unk_ctrl", out_ctrl, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check_eq("unk_ill", out_illegal, 1);
`else
        check_eq("unk_ill", out_illegal, 0);
`endif
        out_ready = 1;
        cycle();

        // Random traffic with occasional flush
        for (int k = 0; k < 250; k++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0);
            cycle();
        end

        // Reset in the middle of traffic drops everything
        drive(1, rand_instr(), 0, 0); cycle();
        drive(1, rand_instr(), 0, 0); cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        sb_q.delete();
        drive(0, 32'h0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            drive(k < 3, rand_instr(), 1, 0);
            cycle();
        end
        check_eq("drain", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
